sort_three_floats_desc_seq: RTL and testbench



---
 rtl/sort_three_floats_desc_seq_pkg.sv | 36 +++
 rtl/sort_three_floats_desc_seq_if.sv | 29 ++
 rtl/sort_three_floats_desc_seq_f_less_or_equal.sv | 47 ++++
 rtl/sort_three_floats_desc_seq.sv | 123 ++++++++++++
 tb/tb_sort_three_floats_desc_seq.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/sort_three_floats_desc_seq_pkg.sv
// ----------------------------------------------------------------------------
// sort_three_floats_desc_seq_pkg
//   Shared types and constants for the sequential three-float sorter.
//   - FLEN       : float width shared by the float pipeline (FP64 here)
//   - triple_t   : three FLEN-bit floats, index 0 is the leftmost element
//   - state_t    : sorter FSM states, 3-bit encoding
//   - cmp_idx()  : lower compare index used by each CMPk state
// ----------------------------------------------------------------------------
package sort_three_floats_desc_seq_pkg;

    localparam int FLEN  = 64;
    localparam int EXP_W = (FLEN == 32) ? 8 : (FLEN == 16) ? 5 : 11;

    typedef logic [0:2][FLEN-1:0] triple_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMP0 = 3'd1,
        CMP1 = 3'd2,
        CMP2 = 3'd3,
        OUT  = 3'd4
    } state_t;

    // Bit k holds the lower index of the pair compared in CMPk:
    // CMP0 -> (0,1), CMP1 -> (1,2), CMP2 -> (0,1). Bit 3 is unused filler.
    localparam logic [3:0] CMP_IDX_TBL = 4'b0010;

    function automatic logic cmp_idx(input state_t s);
        return CMP_IDX_TBL[2'(3'(s) - 3'(CMP0))];
    endfunction

    function automatic logic is_cmp(input state_t s);
        return (s == CMP0) || (s == CMP1) || (s == CMP2);
    endfunction

endpackage

// File: rtl/sort_three_floats_desc_seq_if.sv
// ----------------------------------------------------------------------------
// sort_three_floats_desc_seq_if
//   Upstream (triple in) and downstream (sorted triple out) valid/ready
//   channels of the sorter.
//   master : drives up_valid, unsorted, down_ready (producer + consumer side)
//   slave  : drives up_ready, down_valid, sorted, err (the sorter)
// ----------------------------------------------------------------------------
interface sort_three_floats_desc_seq_if;
    import sort_three_floats_desc_seq_pkg::*;

    logic    up_valid;
    logic    up_ready;
    triple_t unsorted;
    logic    down_valid;
    logic    down_ready;
    triple_t sorted;
    logic    err;

    modport master (
        output up_valid, unsorted, down_ready,
        input  up_ready, down_valid, sorted, err
    );

    modport slave (
        input  up_valid, unsorted, down_ready,
        output up_ready, down_valid, sorted, err
    );

endinterface

// File: rtl/sort_three_floats_desc_seq_f_less_or_equal.sv
// ----------------------------------------------------------------------------
// f_less_or_equal
//   Combinational IEEE-754 compare: o_res = (i_a <= i_b).
//   o_err flags an operand with an all-ones exponent (Inf or NaN); o_res is
//   0 in that case and must not be used.
//   Ports:
//     i_a, i_b : FLEN-bit floats
//     o_res    : 1 when i_a <= i_b (+0 and -0 compare equal)
//     o_err    : 1 when either operand is Inf/NaN
// ----------------------------------------------------------------------------
module f_less_or_equal
    import sort_three_floats_desc_seq_pkg::*;
(
    input  logic [FLEN-1:0] i_a,
    input  logic [FLEN-1:0] i_b,
    output logic            o_res,
    output logic            o_err
);

    logic            w_a_sign, w_b_sign;
    logic [FLEN-2:0] w_a_mag,  w_b_mag;
    logic            w_a_spec, w_b_spec;

    assign w_a_sign = i_a[FLEN-1];
    assign w_b_sign = i_b[FLEN-1];
    assign w_a_mag  = i_a[FLEN-2:0];
    assign w_b_mag  = i_b[FLEN-2:0];
    assign w_a_spec = &i_a[FLEN-2 -: EXP_W];
    assign w_b_spec = &i_b[FLEN-2 -: EXP_W];

    always_comb begin
        o_err = w_a_spec | w_b_spec;
        o_res = 1'b0;
        if (w_a_spec || w_b_spec) begin
            o_res = 1'b0;
        end else if ((w_a_mag == '0) && (w_b_mag == '0)) begin
            o_res = 1'b1;                       // +0 == -0
        end else if (w_a_sign != w_b_sign) begin
            o_res = w_a_sign;                   // negative side is smaller
        end else if (!w_a_sign) begin
            o_res = (w_a_mag <= w_b_mag);       // sign-magnitude: positive
        end else begin
            o_res = (w_a_mag >= w_b_mag);       // larger magnitude is smaller
        end
    end

endmodule

// File: rtl/sort_three_floats_desc_seq.sv
// ----------------------------------------------------------------------------
// sort_three_floats_desc_seq
//   Sorts a triple of FLEN-bit floats with one shared comparator over three
//   cycles (bubble passes on pairs 0-1, 1-2, 0-1), then holds the result on
//   the downstream channel until it is taken.
//   Parameters:
//     DESCENDING : 1 -> sorted[0] >= sorted[1] >= sorted[2]; 0 -> increasing
//   Ports:
//     clk      : clock, rising edge
//     rst_n    : asynchronous active-low reset
//     io_bus   : slave side of the up/down valid/ready channels
//                (up_ready only in IDLE, down_valid only in OUT; sorted and
//                 err are straight from registers)
// ----------------------------------------------------------------------------
module sort_three_floats_desc_seq
    import sort_three_floats_desc_seq_pkg::*;
#(
    parameter bit DESCENDING = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    sort_three_floats_desc_seq_if.slave  io_bus
);

    state_t          r_state;
    state_t          w_state_nxt;
    triple_t         r_work;
    logic            r_err;

    logic            w_up_ready;
    logic            w_down_valid;
    logic            w_accept;
    logic            w_in_cmp;
    logic            w_idx;
    logic [FLEN-1:0] w_lo, w_hi;
    logic [FLEN-1:0] w_a,  w_b;
    logic            w_res;
    logic            w_cmp_err;
    logic            w_swap;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_up_ready   = 1'b0;
        w_down_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_up_ready = 1'b1;
                if (io_bus.up_valid) w_state_nxt = CMP0;
            end
            CMP0: w_state_nxt = CMP1;
            CMP1: w_state_nxt = CMP2;
            CMP2: w_state_nxt = OUT;
            OUT: begin
                w_down_valid = 1'b1;
                if (io_bus.down_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept = (r_state == IDLE) && io_bus.up_valid;
    assign w_in_cmp = is_cmp(r_state);

    // ------------------------------------------------------- compare path
    // w_lo/w_hi are work[i]/work[i+1] for the pair this state compares.
    assign w_idx = cmp_idx(r_state);
    assign w_lo  = w_idx ? r_work[1] : r_work[0];
    assign w_hi  = w_idx ? r_work[2] : r_work[1];

    // Operand order is chosen so that res=0 always means "out of order":
    // descending asks hi <= lo, increasing asks lo <= hi. Equal values
    // give res=1 and never swap, which keeps the sort stable.
    assign w_a = DESCENDING ? w_hi : w_lo;
    assign w_b = DESCENDING ? w_lo : w_hi;

    f_less_or_equal u_cmp (
        .i_a   (w_a),
        .i_b   (w_b),
        .o_res (w_res),
        .o_err (w_cmp_err)
    );

    // A flagged compare leaves the pair untouched; only err records it.
    assign w_swap = w_in_cmp && !w_cmp_err && !w_res;

    // ---------------------------------------------------------- work regs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_work <= io_bus.unsorted;
            r_err  <= 1'b0;
        end else if (w_in_cmp) begin
            if (w_swap) begin
                if (w_idx) begin
                    r_work[1] <= r_work[2];
                    r_work[2] <= r_work[1];
                end else begin
                    r_work[0] <= r_work[1];
                    r_work[1] <= r_work[0];
                end
            end
            if (w_cmp_err) r_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------ outputs
    assign io_bus.up_ready   = w_up_ready;
    assign io_bus.down_valid = w_down_valid;
    assign io_bus.sorted     = r_work;
    assign io_bus.err        = r_err;

endmodule

// File: tb/tb_sort_three_floats_desc_seq.sv
module tb_sort_three_floats_desc_seq;
    import sort_three_floats_desc_seq_pkg::*;

    localparam logic [63:0] ONE   = 64'h3FF0000000000000;
    localparam logic [63:0] TWO   = 64'h4000000000000000;
    localparam logic [63:0] THREE = 64'h4008000000000000;
    localparam logic [63:0] NEG1  = 64'hBFF0000000000000;
    localparam logic [63:0] ZERO  = 64'h0000000000000000;
    localparam logic [63:0] QNAN  = 64'h7FF8000000000000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sort_three_floats_desc_seq_if u0 ();
    sort_three_floats_desc_seq_if u1 ();

    // The increasing-order instance runs in lockstep with the descending one.
    assign u1.up_valid   = u0.up_valid;
    assign u1.unsorted   = u0.unsorted;
    assign u1.down_ready = u0.down_ready;

    sort_three_floats_desc_seq #(.DESCENDING(1'b1)) dut_desc (
        .clk(clk), .rst_n(rst_n), .io_bus(u0.slave));
    sort_three_floats_desc_seq #(.DESCENDING(1'b0)) dut_inc (
        .clk(clk), .rst_n(rst_n), .io_bus(u1.slave));

    // ------------------------------------------------------ reference model
    // Stable selection sort on real values: among equals the earliest wins.
    function automatic triple_t model_sort(input triple_t v, input bit desc);
        triple_t o;
        real     r[3];
        bit      used[3];
        for (int i = 0; i < 3; i++) begin
            r[i] = $bitstoreal(v[i]);
            used[i] = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            int best;
            best = -1;
            for (int i = 0; i < 3; i++)
                if (!used[i] && (best < 0 || (desc ? r[i] > r[best] : r[i] < r[best])))
                    best = i;
            used[best] = 1'b1;
            o[k] = v[best];
        end
        return o;
    endfunction

    function automatic bit model_err(input triple_t v);
        bit e;
        e = 1'b0;
        for (int i = 0; i < 3; i++) if (v[i][62:52] == 11'h7FF) e = 1'b1;
        return e;
    endfunction

    function automatic logic [63:0] rnd_val();
        int unsigned sel;
        real x;
        sel = $urandom_range(0, 9);
        if (sel == 0) begin
            return ($urandom_range(0, 1) != 0) ? QNAN : 64'hFFF0000000000000;
        end else if (sel <= 6) begin
            x = ($itor($urandom_range(0, 64)) - 32.0) / 4.0;
            return $realtobits(x);
        end else begin
            logic [63:0] b;
            b = {$urandom, $urandom};
            b[62:52] = 11'($urandom_range(1, 2046));
            return b;
        end
    endfunction

    // Drives one triple with down_ready held high. acc = cycle of the
    // handshake, lat = cycles from handshake to down_valid seen.
    task automatic run_triple(input triple_t v, output int acc, output int lat,
                              output triple_t s0, output logic e0,
                              output triple_t s1, output logic e1);
        int n;
        n = 0;
        u0.up_valid = 1'b1;
        u0.unsorted = v;
        while (!u0.up_ready && n < 20) begin @(posedge clk); #1; n++; end
        acc = cyc;
        @(posedge clk); #1;
        u0.up_valid = 1'b0;
        u0.unsorted = {3{64'hDEADBEEFCAFEF00D}};
        lat = 1;
        while (!u0.down_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        s0 = u0.sorted; e0 = u0.err;
        s1 = u1.sorted; e1 = u1.err;
        @(posedge clk); #1;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        #12;
        checks++; if (u0.down_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", u0.down_valid); end
        checks++; if (u0.sorted !== '0) begin errors++; $display("FAIL reset_sorted: got %h want 0", u0.sorted); end
        checks++; if (u0.err !== 1'b0 || u1.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b/%b want 0", u0.err, u1.err); end
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (u0.up_ready !== 1'b1) begin errors++; $display("FAIL reset_up_ready: got %b want 1", u0.up_ready); end
    endtask

    task automatic test_basic();
        triple_t v, s0, s1; logic e0, e1; int acc, lat;
        v = {ONE, TWO, THREE};
        run_triple(v, acc, lat, s0, e0, s1, e1);
        checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
        checks++; if (s0 !== triple_t'({THREE, TWO, ONE})) begin errors++; $display("FAIL basic_desc: got %h want %h", s0, {THREE, TWO, ONE}); end
        checks++; if (e0 !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", e0); end
        checks++; if (s1 !== v) begin errors++; $display("FAIL basic_inc: got %h want %h", s1, v); end
        checks++; if (u0.up_ready !== 1'b1) begin errors++; $display("FAIL basic_up_ready_t5: got %b want 1", u0.up_ready); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] vals[3];
        triple_t v, s0, s1; logic e0, e1; int acc, lat, prev;
        vals[0] = NEG1; vals[1] = ZERO; vals[2] = TWO;
        prev = -100;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                for (int k = 0; k < 3; k++)
                    if (i != j && j != k && i != k) begin
                        v = {vals[i], vals[j], vals[k]};
                        run_triple(v, acc, lat, s0, e0, s1, e1);
                        checks++; if (s0 !== triple_t'({TWO, ZERO, NEG1}) || e0 !== 1'b0)
                            begin errors++; $display("FAIL perm_desc: got %h err %b want %h err 0", s0, e0, {TWO, ZERO, NEG1}); end
                        checks++; if (s1 !== triple_t'({NEG1, ZERO, TWO}) || e1 !== 1'b0)
                            begin errors++; $display("FAIL perm_inc: got %h err %b want %h err 0", s1, e1, {NEG1, ZERO, TWO}); end
                        checks++; if (lat !== 4 || (acc - prev) < 5)
                            begin errors++; $display("FAIL perm_timing: got lat %0d gap %0d want lat 4 gap >=5", lat, acc - prev); end
                        prev = acc;
                    end
    endtask

    task automatic test_duplicates();
        triple_t s0, s1; logic e0, e1; int acc, lat;
        run_triple({TWO, TWO, ONE}, acc, lat, s0, e0, s1, e1);
        checks++; if (s0 !== triple_t'({TWO, TWO, ONE}) || e0 !== 1'b0) begin errors++; $display("FAIL dup_desc: got %h err %b want %h err 0", s0, e0, {TWO, TWO, ONE}); end
        checks++; if (s1 !== triple_t'({ONE, TWO, TWO}) || e1 !== 1'b0) begin errors++; $display("FAIL dup_inc: got %h err %b want %h err 0", s1, e1, {ONE, TWO, TWO}); end
    endtask

    task automatic test_nan();
        triple_t s0, s1; logic e0, e1; int acc, lat;
        run_triple({ONE, QNAN, TWO}, acc, lat, s0, e0, s1, e1);
        checks++; if (lat !== 4) begin errors++; $display("FAIL nan_latency: got %0d want 4", lat); end
        checks++; if (e0 !== 1'b1 || e1 !== 1'b1) begin errors++; $display("FAIL nan_err: got %b/%b want 1", e0, e1); end
        checks++; if ($isunknown(s0) || $isunknown(s1)) begin errors++; $display("FAIL nan_x: got %h want no X", s0); end
        run_triple({TWO, ONE, THREE}, acc, lat, s0, e0, s1, e1);
        checks++; if (e0 !== 1'b0 || s0 !== triple_t'({THREE, TWO, ONE})) begin errors++; $display("FAIL nan_clear: got %h err %b want %h err 0", s0, e0, {THREE, TWO, ONE}); end
    endtask

    task automatic test_backpressure();
        triple_t s; logic e; int n; bit bad;
        u0.down_ready = 1'b0;
        u0.up_valid = 1'b1;
        u0.unsorted = {NEG1, THREE, ONE};
        n = 0;
        while (!u0.up_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        u0.up_valid = 1'b0;
        n = 0;
        while (!u0.down_valid && n < 20) begin @(posedge clk); #1; n++; end
        s = u0.sorted; e = u0.err;
        checks++; if (s !== triple_t'({THREE, ONE, NEG1})) begin errors++; $display("FAIL bp_value: got %h want %h", s, {THREE, ONE, NEG1}); end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (u0.sorted !== s || u0.err !== e || u0.down_valid !== 1'b1 || u0.up_ready !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL bp_hold: got dv %b ur %b sorted %h want held %h", u0.down_valid, u0.up_ready, u0.sorted, s); end
        u0.down_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (u0.down_valid !== 1'b0 || u0.up_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got dv %b ur %b want 0 1", u0.down_valid, u0.up_ready); end
    endtask

    task automatic test_reset_mid();
        triple_t s0, s1; logic e0, e1; int acc, lat, n;
        u0.up_valid = 1'b1;
        u0.unsorted = {ONE, THREE, TWO};
        n = 0;
        while (!u0.up_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        u0.up_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++; if (u0.down_valid !== 1'b0) begin errors++; $display("FAIL rstmid_dv: got %b want 0", u0.down_valid); end
        checks++; if (u0.sorted !== '0 || u1.sorted !== '0) begin errors++; $display("FAIL rstmid_sorted: got %h want 0", u0.sorted); end
        @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (u0.up_ready !== 1'b1) begin errors++; $display("FAIL rstmid_up_ready: got %b want 1", u0.up_ready); end
        run_triple({TWO, NEG1, THREE}, acc, lat, s0, e0, s1, e1);
        checks++; if (s0 !== triple_t'({THREE, TWO, NEG1}) || e0 !== 1'b0 || lat !== 4) begin errors++; $display("FAIL rstmid_after: got %h err %b lat %0d want %h", s0, e0, lat, {THREE, TWO, NEG1}); end
    endtask

    task automatic test_random();
        triple_t v, s0, s1, x0, x1; logic e0, e1; int acc, lat;
        for (int it = 0; it < 60; it++) begin
            v = {rnd_val(), rnd_val(), rnd_val()};
            run_triple(v, acc, lat, s0, e0, s1, e1);
            checks++;
            if (model_err(v)) begin
                if (e0 !== 1'b1 || e1 !== 1'b1 || lat !== 4) begin errors++; $display("FAIL rand_err: in %h got err %b/%b lat %0d want 1 4", v, e0, e1, lat); end
            end else begin
                x0 = model_sort(v, 1'b1);
                x1 = model_sort(v, 1'b0);
                if (s0 !== x0 || s1 !== x1 || e0 !== 1'b0 || e1 !== 1'b0 || lat !== 4) begin
                    errors++;
                    $display("FAIL rand_sort: in %h got %h/%h want %h/%h", v, s0, s1, x0, x1);
                end
            end
        end
    endtask

    initial begin
        u0.up_valid   = 1'b0;
        u0.unsorted   = '0;
        u0.down_ready = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_duplicates();
        test_nan();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
